zeroriscy_prefetch_queue: RTL

Parametrised instruction prefetch queue for the zero-riscy fetch stage. It sits between the IF stage and the instruction memory port. It issues word fetches ahead of the core with up to `MAX_OUTSTANDING` transactions in flight, and buffers responses in a `DEPTH`-entry FIFO tagged with their fetch address. Branches flush the FIFO and discard stale in-flight responses.

---
 rtl/zeroriscy_prefetch_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/zeroriscy_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_prefetch_queue
// Brief    : Instruction prefetch queue for the zero-riscy fetch stage.
//            Issues word fetches ahead of the core with up to MAX_OUTSTANDING
//            requests in flight and buffers responses, tagged with their
//            fetch address, in a DEPTH-entry FIFO. A branch flushes the FIFO
//            and drops responses that are still in flight.
// Options  : `define ZR_PREFETCH_BYPASS_EN passes a response straight to the
//            outputs in the same cycle when the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module zeroriscy_prefetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  output logic        busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_addr;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [CW-1:0] count;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          req_pending;

  logic [CW-1:0] count_eff;
  logic [31:0]   live_words;
  logic [31:0]   branch_target;
  logic [31:0]   resp_addr;
  logic          can_issue;
  logic          grant;
  logic          rvalid_ok;
  logic          resp_live;
  logic          push;
  logic          pop;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];
  assign branch_target   = {addr_i[31:2], 2'b00};

  // Responses still owed to the current stream; each one owns a FIFO slot.
  assign live_words = 32'(outstanding) - 32'(discard);
  assign count_eff  = branch_i ? '0 : count;

  // Issue only while every granted live response is guaranteed a slot.
  assign can_issue = req_i && (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                     ((32'(count_eff) + live_words) < 32'(DEPTH));

  // A request that was not granted is held until it is.
  assign instr_req_o  = !rst && (req_pending || can_issue);
  assign instr_addr_o = rst ? '0 : (branch_i ? branch_target : fetch_addr);
  assign grant        = instr_req_o && instr_gnt_i;
  assign busy_o       = !rst && ((outstanding != '0) || instr_req_o);

  // Live requests form a contiguous run ending just below fetch_addr,
  // so the oldest one sits live_words words back.
  assign resp_addr = fetch_addr - (live_words << 2);
  assign rvalid_ok = instr_rvalid_i && (outstanding != '0);
  assign resp_live = rvalid_ok && (discard == '0) && !branch_i;
  assign pop       = ready_i && (count != '0) && !branch_i;

`ifdef ZR_PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass  = resp_live && (count == '0);
  assign push    = resp_live && !(bypass && ready_i);
  assign valid_o = !rst && !branch_i && ((count != '0) || bypass);
  assign rdata_o = bypass ? instr_rdata_i : data_mem[rptr];
  assign addr_o  = bypass ? resp_addr : addr_mem[rptr];
`else
  assign push    = resp_live;
  assign valid_o = !rst && !branch_i && (count != '0);
  assign rdata_o = data_mem[rptr];
  assign addr_o  = addr_mem[rptr];
`endif

  // Fetch address, held-request flag and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr  <= '0;
      req_pending <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      req_pending <= instr_req_o && !instr_gnt_i;

      if (grant) begin
        fetch_addr <= instr_addr_o + 32'd4;
      end else if (branch_i) begin
        fetch_addr <= branch_target;
      end

      if (grant && !rvalid_ok) begin
        outstanding <= outstanding + OW'(1);
      end else if (!grant && rvalid_ok) begin
        outstanding <= outstanding - OW'(1);
      end

      // Everything in flight at a branch belongs to the old stream.
      if (branch_i) begin
        discard <= outstanding - OW'(rvalid_ok);
      end else if (rvalid_ok && (discard != '0)) begin
        discard <= discard - OW'(1);
      end
    end
  end

  // Response FIFO of {address, data}; a branch empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (branch_i) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      if (push) begin
        addr_mem[wptr] <= resp_addr;
        data_mem[wptr] <= instr_rdata_i;
        wptr           <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire
